// File: rtl/cic_n1_m1_interp_16bit.sv
// Single-stage CIC interpolator: comb at the audio rate, zero-stuff by R, integrate per rf_en tick.
// One-entry input buffer with valid/ready; output saturated to 16 bits and registered.
module cic_n1_m1_interp_16bit #(
   parameter int R = 256
) (
   input  logic        rf_clk,
   input  logic        reset,
   input  logic        rf_en,
   input  logic [15:0] audio_in,
   input  logic        audio_valid,
   output logic        audio_ready,
   output logic [15:0] rf_out,
   output logic        rf_valid,
   output logic        frame_start,
   output logic        underrun,
   input  logic        underrun_clr
);

   localparam int PW = $clog2(R);
   localparam logic [PW-1:0] LAST = PW'(R - 1);

   logic [PW-1:0]       phase;
   logic signed [15:0]  sample_buf;
   logic signed [15:0]  prev;
   logic                pending;
   logic signed [17:0]  integ;
   logic signed [17:0]  integ_next;
   logic signed [16:0]  comb;
   logic [15:0]         sat;
   logic                load;
   logic                accept;

   assign audio_ready = !pending && !reset;
   assign accept      = audio_valid && audio_ready;
   assign load        = rf_en && (phase == LAST);

   always_comb begin
      comb = '0;
      if (load && pending)
         comb = {sample_buf[15], sample_buf} - {prev[15], prev};
      // comb is zero outside load ticks, which is the zero-stuffing
      integ_next = integ + {comb[16], comb};
      if (integ_next > 18'sd32767)
         sat = 16'h7fff;
      else if (integ_next < -18'sd32768)
         sat = 16'h8000;
      else
         sat = integ_next[15:0];
   end

   always_ff @(posedge rf_clk) begin
      if (reset) begin
         phase       <= LAST;
         sample_buf  <= '0;
         prev        <= '0;
         pending     <= 1'b0;
         integ       <= '0;
         rf_out      <= '0;
         rf_valid    <= 1'b0;
         frame_start <= 1'b0;
         underrun    <= 1'b0;
      end else begin
         if (rf_en) begin
            phase  <= load ? '0 : phase + 1'b1;
            integ  <= integ_next;
            rf_out <= sat;
         end
         rf_valid    <= rf_en;
         frame_start <= load;
         if (load && pending) begin
            prev    <= sample_buf;
            pending <= 1'b0;
         end
         // accept only happens with pending clear, so it never collides with the load above
         if (accept) begin
            sample_buf <= audio_in;
            pending    <= 1'b1;
         end
         if (load && !pending)
            underrun <= 1'b1;
         else if (underrun_clr)
            underrun <= 1'b0;
      end
   end

endmodule

// File: doc/cic_n1_m1_interp_16bit.md
# cic_n1_m1_interp_16bit

Single-stage (N=1, M=1) CIC interpolator, the transmit-side counterpart of the audio-rate CIC decimator. It accepts 16-bit signed audio samples through a valid/ready handshake at the low (audio) rate. Each sample is comb-filtered, zero-stuffed by ratio R and integrated at the high rate defined by a clock-enable. The result is a 16-bit signed high-rate stream for the RF/DAC path. Everything runs on one clock; the high rate is the `rf_en` tick rate.

## Interface
- `R`, default 256: interpolation ratio, high-rate ticks per audio sample; legal range 2..65536.
- `rf_clk`  input  1  the only clock; all state updates on the rising edge.
- `reset`  input  1  synchronous, active-high reset.
- `rf_en`  input  1  high-rate tick; the datapath advances only on cycles where it is 1.
- `audio_in`  input  16  signed 2's-complement audio sample.
- `audio_valid`  input  1  `audio_in` is valid.
- `audio_ready`  output  1  block can accept a sample this cycle.
- `rf_out`  output  16  signed interpolated output, registered.
- `rf_valid`  output  1  `rf_out` was updated this cycle; one-cycle pulse per `rf_en`.
- `frame_start`  output  1  qualifies `rf_valid`; marks the first output of each new audio sample period.
- `underrun`  output  1  sticky flag: a load tick found no pending sample.
- `underrun_clr`  input  1  clears `underrun`.

## Operation
- Input buffer: one entry (`buf`, `pending`).
  - `audio_ready` = !pending && !reset.
  - A transfer occurs when `audio_valid && audio_ready`: `buf` <= `audio_in`, `pending` <= 1.
- Phase counter: width clog2(R).
  - Advances only on `rf_en`, counting 0..R-1 and wrapping from R-1 to 0.
  - A load tick is `rf_en && phase == R-1`.
- Comb, evaluated on the load tick, 17-bit signed:
  - If `pending`: `comb` = `buf` - `prev`; then `prev` <= `buf` and `pending` <= 0.
  - If not `pending`: `comb` = 0, `prev` is unchanged, and `underrun` <= 1.
- Zero-stuff and integrate: 18-bit signed `integ`, updated on every `rf_en`.
  - `integ` <= `integ` + (load tick ? sign-extended `comb` : 0).
  - Arithmetic is modular 18-bit. Exact arithmetic keeps `integ` equal to the last loaded sample, so no overflow occurs in legal operation.
- Output, on every `rf_en`:
  - `rf_out` <= saturate16(`integ_next`), clamped to [-32768, 32767].
  - `rf_valid` <= 1, and `frame_start` <= 1 when the tick was a load tick.
  - On cycles without `rf_en`: `rf_valid` <= 0, `frame_start` <= 0, `rf_out` holds.
- `underrun` is set as above and cleared by `underrun_clr`. If both happen in the same cycle, set wins.
- Functionally the output is a zero-order hold: each accepted sample is repeated R times.

## Timing
- Reset values:
  - `phase` = R-1, so the first `rf_en` after reset is a load tick.
  - `buf`, `prev`, `integ`, `rf_out` = 0.
  - `pending`, `rf_valid`, `frame_start`, `underrun` = 0.
  - `audio_ready` = 0 while `reset` is high and 1 in the first cycle after.
- Reset mid-operation discards the pending sample and the phase. Output resumes from 0.
- Handshake:
  - At most one sample is held.
  - `audio_ready` falls in the cycle after an accept and rises in the cycle after the load tick that consumes `buf`.
  - No accept can coincide with a load of the same entry.
- Latency: a sample accepted in cycle t appears on `rf_out` in the cycle after the first load tick at or after cycle t+1, with `rf_valid` and `frame_start` both asserted.
- `rf_out` is updated exactly one cycle after each `rf_en`. Gaps in `rf_en` stall the phase, the integrator and the output.
- `rf_en` held high every cycle is legal, giving full-rate output.
- The upstream source must deliver one sample per R ticks; otherwise an underrun occurs.

## Test plan
- Reset:
  - Stimulus: assert `reset` for 3 cycles with `audio_valid`=1.
  - Required: all outputs 0 and `audio_ready`=0 during reset; `audio_ready`=1 in the first cycle after; no accept during reset.
- Steady state:
  - Stimulus: R=4, `rf_en` tied high, feed 1000 then -2000 back-to-back.
  - Required: `rf_out` = 1000 ×4 then -2000 ×4; `frame_start` on the first of each group; `rf_valid` every cycle.
- Underrun:
  - Stimulus: R=4, feed 1000, then withhold input.
  - Required: `rf_out` stays 1000, `underrun`=1 after the second load tick.
  - Stimulus: pulse `underrun_clr` in the same cycle as a new underrun.
  - Required: `underrun` remains 1; a later lone `underrun_clr` clears it.
- Gapped enable:
  - Stimulus: R=4, `rf_en` every 3rd cycle.
  - Required: `rf_valid` pulses exactly one cycle after each `rf_en`; one new sample is consumed per 4 `rf_en` ticks; `rf_out` holds between ticks.
- Full-scale swing:
  - Stimulus: feed 32767, -32768, 32767.
  - Required: `rf_out` reproduces each value exactly for R outputs; no wrap or saturation artefacts.
- Reset mid-frame:
  - Stimulus: R=4, `rf_out`=500 with a pending 700; pulse `reset`.
  - Required: 700 is discarded; with no new input, the first post-reset output is 0 with `frame_start`=1 and `underrun`=1.
